// File: rtl/mario_animator.sv
// Mario pose sequencer: turns motion flags and the per-frame tick into the 4-bit
// sprite pose code, plus a one-cycle pulse when the death animation completes.
module mario_animator #(
    parameter int WALK_DIV  = 4,
    parameter int CLIMB_DIV = 6,
    parameter int DIE_DIV   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [1:0] move_dir,
    input  logic       airborne,
    input  logic       climb,
    input  logic       vmove,
    input  logic       hit,
    input  logic       revive,
    output logic [3:0] animate_state,
    output logic       facing,
    output logic       die_done
);

    // m_hold: death animation finished, pose 13 frozen until revive
    typedef enum logic [2:0] {
        M_STAND,
        M_WALK_L,
        M_WALK_R,
        M_AIR,
        M_CLIMB,
        M_DEAD,
        M_HOLD
    } mode_t;

    localparam logic [7:0] WALK_LAST  = 8'(WALK_DIV - 1);
    localparam logic [7:0] CLIMB_LAST = 8'(CLIMB_DIV - 1);
    localparam logic [7:0] DIE_LAST   = 8'(DIE_DIV - 1);

    mode_t      mode, mode_n, target;
    logic [7:0] cnt, cnt_n;
    logic [1:0] phase, phase_n;
    logic       facing_n;
    logic       done_n;
    logic [3:0] pose_n;

    function automatic logic [3:0] pose_of(input mode_t m, input logic [1:0] p, input logic f);
        logic [3:0] r;
        r = 4'd0;
        case (m)
            M_STAND:  r = 4'd0;
            M_WALK_L: r = (p == 2'd0) ? 4'd1 : (p == 2'd1) ? 4'd2 : 4'd3;
            M_WALK_R: r = (p == 2'd0) ? 4'd4 : (p == 2'd1) ? 4'd5 : 4'd3;
            M_AIR:    r = f ? 4'd7 : 4'd6;
            M_CLIMB:  r = p[0] ? 4'd9 : 4'd8;
            M_DEAD:   r = 4'd10 + {2'b00, p};
            M_HOLD:   r = 4'd13;
            default:  r = 4'd0;
        endcase
        return r;
    endfunction

    always_comb begin
        mode_n   = mode;
        cnt_n    = cnt;
        phase_n  = phase;
        facing_n = facing;
        done_n   = 1'b0;
        target   = M_STAND;

        case (mode)
            M_DEAD: begin
                if (frame_tick) begin
                    if (cnt == DIE_LAST) begin
                        cnt_n = 8'd0;
                        if (phase == 2'd3) begin
                            mode_n = M_HOLD;
                            done_n = 1'b1;
                        end else begin
                            phase_n = phase + 2'd1;
                        end
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
            end

            M_HOLD: begin
                if (revive) begin
                    mode_n  = M_STAND;
                    cnt_n   = 8'd0;
                    phase_n = 2'd0;
                end
            end

            default: begin
                if (move_dir == 2'b01)
                    facing_n = 1'b0;
                else if (move_dir == 2'b10)
                    facing_n = 1'b1;

                if (climb)
                    target = M_CLIMB;
                else if (airborne)
                    target = M_AIR;
                else if (move_dir == 2'b01)
                    target = M_WALK_L;
                else if (move_dir == 2'b10)
                    target = M_WALK_R;
                else
                    target = M_STAND;

                // a tick on a mode-change edge is deliberately not counted
                if (hit) begin
                    mode_n  = M_DEAD;
                    cnt_n   = 8'd0;
                    phase_n = 2'd0;
                end else if (target != mode) begin
                    mode_n  = target;
                    cnt_n   = 8'd0;
                    phase_n = 2'd0;
                end else if ((mode == M_WALK_L || mode == M_WALK_R) && frame_tick) begin
                    if (cnt == WALK_LAST) begin
                        cnt_n   = 8'd0;
                        phase_n = (phase == 2'd2) ? 2'd0 : phase + 2'd1;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end else if (mode == M_CLIMB && frame_tick && vmove) begin
                    if (cnt == CLIMB_LAST) begin
                        cnt_n   = 8'd0;
                        phase_n = {1'b0, ~phase[0]};
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
            end
        endcase

        pose_n = pose_of(mode_n, phase_n, facing_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode          <= M_STAND;
            cnt           <= 8'd0;
            phase         <= 2'd0;
            facing        <= 1'b1;
            die_done      <= 1'b0;
            animate_state <= 4'd0;
        end else begin
            mode          <= mode_n;
            cnt           <= cnt_n;
            phase         <= phase_n;
            facing        <= facing_n;
            die_done      <= done_n;
            animate_state <= pose_n;
        end
    end

endmodule

// File: tb/tb_mario_animator.sv
// Bench for mario_animator: table of mode-priority vectors plus hand-written
// walk/climb/death sequences, all checked through an expectation queue.
module tb_mario_animator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic [1:0] move_dir = 2'b00;
    logic       airborne = 1'b0;
    logic       climb = 1'b0;
    logic       vmove = 1'b0;
    logic       hit = 1'b0;
    logic       revive = 1'b0;
    logic [3:0] animate_state;
    logic       facing;
    logic       die_done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string tag;
        int    anim;
        int    fac;   // -1: facing not checked
        int    done;
    } exp_t;

    typedef struct {
        int md;
        int air;
        int clb;
        int vm;
        int tk;
        int anim;
        int fac;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[10];
    int   wr_pose[3];

    always #5 clk = ~clk;

    mario_animator #(.WALK_DIV(4), .CLIMB_DIV(6), .DIE_DIV(8)) dut (
        .clk(clk),
        .rst(rst),
        .frame_tick(frame_tick),
        .move_dir(move_dir),
        .airborne(airborne),
        .climb(climb),
        .vmove(vmove),
        .hit(hit),
        .revive(revive),
        .animate_state(animate_state),
        .facing(facing),
        .die_done(die_done)
    );

    task automatic chk(input string tag, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, expv);
        end
    endtask

    // one clock of stimulus; an expectation is queued when ea >= 0
    task automatic cyc(input string tag, input int md, input int air, input int clb,
                       input int vm, input int tk, input int h, input int rv,
                       input int ea, input int ef, input int ed);
        exp_t e;
        @(negedge clk);
        move_dir   = 2'(md);
        airborne   = (air != 0);
        climb      = (clb != 0);
        vmove      = (vm != 0);
        frame_tick = (tk != 0);
        hit        = (h != 0);
        revive     = (rv != 0);
        if (ea >= 0) begin
            e.tag  = tag;
            e.anim = ea;
            e.fac  = ef;
            e.done = ed;
            sb.push_back(e);
        end
    endtask

    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.tag, " pose"}, int'(animate_state), e.anim);
                if (e.fac >= 0)
                    chk({e.tag, " facing"}, int'(facing), e.fac);
                chk({e.tag, " die_done"}, int'(die_done), e.done);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        wr_pose[0] = 4; wr_pose[1] = 5; wr_pose[2] = 3;
        //           md air clb vm tk anim fac
        tbl[0] = '{0, 0, 0, 0, 0, 0, 1};
        tbl[1] = '{2, 0, 0, 0, 1, 4, 1};
        tbl[2] = '{2, 1, 0, 0, 1, 7, 1};
        tbl[3] = '{1, 1, 0, 0, 0, 6, 0};
        tbl[4] = '{1, 1, 1, 1, 1, 8, 0};
        tbl[5] = '{3, 0, 0, 0, 0, 0, 0};
        tbl[6] = '{1, 0, 0, 0, 1, 1, 0};
        tbl[7] = '{0, 0, 0, 0, 0, 0, 0};
        tbl[8] = '{3, 1, 0, 0, 0, 6, 0};
        tbl[9] = '{0, 0, 0, 0, 0, 0, 0};

        @(posedge clk);
        #1;
        chk("reset pose", int'(animate_state), 0);
        chk("reset facing", int'(facing), 1);
        chk("reset die_done", int'(die_done), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            cyc($sformatf("vec%0d", i), tbl[i].md, tbl[i].air, tbl[i].clb, tbl[i].vm,
                tbl[i].tk, 0, 0, tbl[i].anim, tbl[i].fac, 0);

        // walk right, WALK_DIV=4
        cyc("wr entry", 2, 0, 0, 0, 0, 0, 0, 4, 1, 0);
        for (int k = 1; k <= 12; k++)
            cyc($sformatf("wr tick%0d", k), 2, 0, 0, 0, 1, 0, 0, wr_pose[(k / 4) % 3], 1, 0);
        cyc("wr tick13", 2, 0, 0, 0, 1, 0, 0, 4, 1, 0);
        cyc("wr tick14", 2, 0, 0, 0, 1, 0, 0, 4, 1, 0);
        cyc("reverse", 1, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 4; k++)
            cyc($sformatf("wl tick%0d", k), 1, 0, 0, 0, 1, 0, 0, (k < 4) ? 1 : 2, 0, 0);

        // jump, then ladder
        cyc("jump", 1, 1, 0, 0, 0, 0, 0, 6, 0, 0);
        cyc("climb entry", 1, 1, 1, 0, 0, 0, 0, 8, 0, 0);
        for (int k = 1; k <= 20; k++)
            cyc($sformatf("climb frozen%0d", k), 1, 1, 1, 0, 1, 0, 0, 8, 0, 0);
        for (int k = 1; k <= 6; k++)
            cyc($sformatf("climb tick%0d", k), 1, 1, 1, 1, 1, 0, 0, (k < 6) ? 8 : 9, 0, 0);
        cyc("climb no tick", 1, 1, 1, 1, 0, 0, 0, 9, 0, 0);

        // death during walk, DIE_DIV=8, motion/revive/hit ignored
        cyc("pre-death walk", 2, 0, 0, 0, 0, 0, 0, 4, 1, 0);
        cyc("pre-death t1", 2, 0, 0, 0, 1, 0, 0, 4, 1, 0);
        cyc("pre-death t2", 2, 0, 0, 0, 1, 0, 0, 4, 1, 0);
        cyc("hit", 2, 0, 0, 0, 0, 1, 0, 10, 1, 0);
        for (int k = 1; k <= 32; k++)
            cyc($sformatf("die tick%0d", k), (k % 2 == 1) ? 1 : 2, (k == 20) ? 1 : 0, 0, 0, 1,
                (k == 10) ? 1 : 0, (k == 5) ? 1 : 0,
                (k < 32) ? 10 + k / 8 : 13, 1, (k == 32) ? 1 : 0);
        cyc("done drop", 0, 0, 0, 0, 0, 0, 0, 13, 1, 0);
        for (int k = 1; k <= 10; k++)
            cyc($sformatf("hold tick%0d", k), 1, 1, 0, 0, 1, 0, 0, 13, 1, 0);
        cyc("revive", 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        cyc("after revive", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // revive in the same cycle die_done is high
        cyc("hit2", 1, 0, 0, 0, 0, 1, 0, 10, 0, 0);
        for (int k = 1; k <= 30; k++)
            cyc("die2", 0, 0, 0, 0, 1, 0, 0, -1, 0, 0);
        cyc("die2 tick31", 0, 0, 0, 0, 1, 0, 0, 13, 0, 0);
        cyc("die2 tick32", 0, 0, 0, 0, 1, 0, 0, 13, 0, 1);
        cyc("revive on done", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc("stand idle", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        // hit + tick + direction change on one edge: tick not counted
        cyc("walk3", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc("walk3 t1", 1, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        cyc("walk3 t2", 1, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        cyc("hit same cycle", 2, 0, 0, 0, 1, 1, 0, 10, -1, 0);
        for (int k = 1; k <= 8; k++)
            cyc($sformatf("die3 tick%0d", k), 0, 0, 0, 0, 1, 0, 0, (k < 8) ? 10 : 11, -1, 0);

        // asynchronous reset mid-death
        @(negedge clk);
        frame_tick = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst mid-death pose", int'(animate_state), 0);
        chk("rst mid-death facing", int'(facing), 1);
        chk("rst mid-death die_done", int'(die_done), 0);
        @(negedge clk);
        rst = 1'b0;

        // asynchronous reset mid-walk
        cyc("walk4", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 5; k++)
            cyc($sformatf("walk4 tick%0d", k), 1, 0, 0, 0, 1, 0, 0, (k < 4) ? 1 : 2, 0, 0);
        @(negedge clk);
        frame_tick = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst mid-walk pose", int'(animate_state), 0);
        chk("rst mid-walk facing", int'(facing), 1);
        chk("rst mid-walk die_done", int'(die_done), 0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
